// File: rtl/symtab_lookup_stage.sv
// Sequencer between the ITCH parser and symtab_cam: one lookup per message, timeout guard, saturating counters.
// Optional build macro SYMTAB_MISS_DROP_EN: misses and timeouts are counted but not emitted downstream.
module symtab_lookup_stage #(
  parameter int KEY_WIDTH      = 64,
  parameter int IDX_WIDTH      = 10,
  parameter int META_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [KEY_WIDTH-1:0]  in_key,
  input  logic [META_WIDTH-1:0] in_meta,
  output logic [KEY_WIDTH-1:0]  cam_lookup_key,
  output logic                  cam_lookup_valid,
  input  logic [IDX_WIDTH-1:0]  cam_lookup_idx,
  input  logic                  cam_lookup_hit,
  input  logic                  cam_lookup_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_hit,
  output logic [META_WIDTH-1:0] out_meta,
  output logic [31:0]           cnt_hit,
  output logic [31:0]           cnt_miss,
  output logic [31:0]           cnt_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

`ifdef SYMTAB_MISS_DROP_EN
  localparam state_t MISS_NEXT = S_IDLE;
`else
  localparam state_t MISS_NEXT = S_OUT;
`endif

  state_t                r_state;
  logic [KEY_WIDTH-1:0]  r_key;
  logic [META_WIDTH-1:0] r_meta;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_hit;
  logic [7:0]            r_tmo_cnt;
  logic [31:0]           r_cnt_hit;
  logic [31:0]           r_cnt_miss;
  logic [31:0]           r_cnt_timeout;

  // Handshake outputs decode directly from the registered state.
  assign in_ready         = (r_state == S_IDLE);
  assign cam_lookup_valid = (r_state == S_REQ);
  assign out_valid        = (r_state == S_OUT);
  assign cam_lookup_key   = r_key;
  assign out_meta         = r_meta;
  assign out_idx          = r_idx;
  assign out_hit          = r_hit;
  assign cnt_hit          = r_cnt_hit;
  assign cnt_miss         = r_cnt_miss;
  assign cnt_timeout      = r_cnt_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_meta        <= '0;
      r_idx         <= '0;
      r_hit         <= 1'b0;
      r_tmo_cnt     <= '0;
      r_cnt_hit     <= '0;
      r_cnt_miss    <= '0;
      r_cnt_timeout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_key   <= in_key;
            r_meta  <= in_meta;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // A strobe in the timeout cycle wins over the timeout.
          if (cam_lookup_ready) begin
            if (cam_lookup_hit) begin
              r_idx   <= cam_lookup_idx;
              r_hit   <= 1'b1;
              r_state <= S_OUT;
              if (r_cnt_hit != 32'hFFFF_FFFF) r_cnt_hit <= r_cnt_hit + 32'd1;
            end else begin
              r_idx   <= '0;
              r_hit   <= 1'b0;
              r_state <= MISS_NEXT;
              if (r_cnt_miss != 32'hFFFF_FFFF) r_cnt_miss <= r_cnt_miss + 32'd1;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_state <= MISS_NEXT;
            if (r_cnt_timeout != 32'hFFFF_FFFF) r_cnt_timeout <= r_cnt_timeout + 32'd1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symtab_lookup_stage.sv
// Directed bench for symtab_lookup_stage; the CAM side is driven by hand with fixed probe counts.
// Honours SYMTAB_MISS_DROP_EN the same way the design does.
module tb_symtab_lookup_stage;

  localparam int KW = 64;
  localparam int IW = 10;
  localparam int MW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [KW-1:0] in_key;
  logic [MW-1:0] in_meta;
  logic [KW-1:0] cam_lookup_key;
  logic          cam_lookup_valid;
  logic [IW-1:0] cam_lookup_idx;
  logic          cam_lookup_hit;
  logic          cam_lookup_ready;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_hit;
  logic [MW-1:0] out_meta;
  logic [31:0]   cnt_hit;
  logic [31:0]   cnt_miss;
  logic [31:0]   cnt_timeout;

  int n_checks = 0;
  int n_errors = 0;

  symtab_lookup_stage #(
    .KEY_WIDTH(KW), .IDX_WIDTH(IW), .META_WIDTH(MW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_meta(in_meta),
    .cam_lookup_key(cam_lookup_key), .cam_lookup_valid(cam_lookup_valid),
    .cam_lookup_idx(cam_lookup_idx), .cam_lookup_hit(cam_lookup_hit),
    .cam_lookup_ready(cam_lookup_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_hit(out_hit), .out_meta(out_meta),
    .cnt_hit(cnt_hit), .cnt_miss(cnt_miss), .cnt_timeout(cnt_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after an edge with the stage idle; returns in cycle accept+1.
  task automatic accept(input logic [KW-1:0] key, input logic [MW-1:0] meta);
    in_key   = key;
    in_meta  = meta;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lookup_pulse", cam_lookup_valid, 1'b1);
    check("lookup_key", cam_lookup_key, key);
  endtask

  // Strobe in cycle accept+2+p; returns in cycle accept+3+p.
  task automatic respond(input int p, input logic hit, input logic [IW-1:0] idx);
    tick();
    check("pulse_one_cycle", cam_lookup_valid, 1'b0);
    repeat (p) tick();
    cam_lookup_ready = 1'b1;
    cam_lookup_hit   = hit;
    cam_lookup_idx   = idx;
    check("no_early_out", out_valid, 1'b0);
    tick();
    cam_lookup_ready = 1'b0;
    cam_lookup_hit   = 1'b0;
    cam_lookup_idx   = '0;
  endtask

  localparam logic [KW-1:0] K_AAPL = 64'h4141_504C_2020_2020;
  localparam logic [KW-1:0] K_MSFT = 64'h4D53_4654_2020_2020;
  localparam logic [KW-1:0] K_IBM  = 64'h4942_4D20_2020_2020;
  localparam logic [KW-1:0] K_TSLA = 64'h5453_4C41_2020_2020;
  localparam logic [MW-1:0] M1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [MW-1:0] M2 = 128'hDEAD_BEEF_0000_0001_0000_0000_0000_0002;
  localparam logic [MW-1:0] M3 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [MW-1:0] M4 = 128'hC0FF_EE00_1111_2222_3333_4444_5555_6666;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_key = '0; in_meta = '0;
    cam_lookup_idx = '0; cam_lookup_hit = 1'b0; cam_lookup_ready = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lookup_valid", cam_lookup_valid, 1'b0);
    check("rst_lookup_key", cam_lookup_key, '0);
    check("rst_out_idx", out_idx, '0);
    check("rst_out_hit", out_hit, 1'b0);
    check("rst_out_meta", out_meta, '0);
    check("rst_cnt_hit", cnt_hit, 32'd0);
    check("rst_cnt_miss", cnt_miss, 32'd0);
    check("rst_cnt_timeout", cnt_timeout, 32'd0);

    // First-probe hit: out_valid at accept+4
    accept(K_AAPL, M1);
    respond(1, 1'b1, 10'd37);
    check("hit_out_valid", out_valid, 1'b1);
    check("hit_out_idx", out_idx, 10'd37);
    check("hit_out_hit", out_hit, 1'b1);
    check("hit_out_meta", out_meta, M1);
    check("hit_cnt_hit", cnt_hit, 32'd1);
    check("hit_in_ready_busy", in_ready, 1'b0);
    tick();
    check("hit_done_out_valid", out_valid, 1'b0);
    check("hit_done_in_ready", in_ready, 1'b1);

    // Miss with nonzero idx from the CAM
    accept(K_MSFT, M2);
    respond(2, 1'b0, 10'd5);
    check("miss_cnt_miss", cnt_miss, 32'd1);
    check("miss_cnt_hit", cnt_hit, 32'd1);
`ifdef SYMTAB_MISS_DROP_EN
    check("miss_drop_out_valid", out_valid, 1'b0);
    check("miss_drop_in_ready", in_ready, 1'b1);
`else
    check("miss_out_valid", out_valid, 1'b1);
    check("miss_out_hit", out_hit, 1'b0);
    check("miss_out_idx", out_idx, 10'd0);
    check("miss_out_meta", out_meta, M2);
    tick();
    check("miss_done_in_ready", in_ready, 1'b1);
`endif

    // Timeout: CAM never strobes
    accept(K_IBM, M3);
    n = 0;
`ifdef SYMTAB_MISS_DROP_EN
    while (!in_ready && n < 40) begin tick(); n++; end
    check("tmo_returned_idle", in_ready, 1'b1);
    check("tmo_drop_out_valid", out_valid, 1'b0);
`else
    while (!out_valid && n < 40) begin tick(); n++; end
    check("tmo_out_valid", out_valid, 1'b1);
    check("tmo_out_hit", out_hit, 1'b0);
    check("tmo_out_idx", out_idx, 10'd0);
    tick();
`endif
    check("tmo_not_too_early", (n >= 15) ? 1'b1 : 1'b0, 1'b1);
    check("tmo_cnt_timeout", cnt_timeout, 32'd1);
    check("tmo_cnt_miss", cnt_miss, 32'd1);
    // Late strobe three cycles after the forced result
    repeat (2) tick();
    cam_lookup_ready = 1'b1; cam_lookup_hit = 1'b1; cam_lookup_idx = 10'd7;
    tick();
    cam_lookup_ready = 1'b0; cam_lookup_hit = 1'b0; cam_lookup_idx = '0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("late_strobe_no_output", n, 0);
    check("late_strobe_cnt_hit", cnt_hit, 32'd1);

    // Backpressure: 10 stalled cycles, competing input must not be taken
    out_ready = 1'b0;
    accept(K_TSLA, M4);
    respond(3, 1'b1, 10'd99);
    in_key = K_AAPL; in_meta = M1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_idx", out_idx, 10'd99);
      check("bp_out_meta", out_meta, M4);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_no_lookup", cam_lookup_valid, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_released_out_valid", out_valid, 1'b0);
    check("bp_released_in_ready", in_ready, 1'b1);
    check("bp_cnt_hit", cnt_hit, 32'd2);
    // Next message, slowest CAM response
    accept(K_MSFT, M2);
    respond(8, 1'b1, 10'd1023);
    check("p8_out_valid", out_valid, 1'b1);
    check("p8_out_idx", out_idx, 10'd1023);
    check("p8_out_meta", out_meta, M2);
    check("p8_cnt_hit", cnt_hit, 32'd3);
    tick();

    // Reset during S_WAIT
    accept(K_AAPL, M3);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_cnt_hit", cnt_hit, 32'd0);
    check("midrst_cnt_miss", cnt_miss, 32'd0);
    check("midrst_cnt_timeout", cnt_timeout, 32'd0);
    cam_lookup_ready = 1'b1; cam_lookup_hit = 1'b1; cam_lookup_idx = 10'd3;
    tick();
    cam_lookup_ready = 1'b0; cam_lookup_hit = 1'b0; cam_lookup_idx = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("midrst_strobe_no_output", n, 0);
    check("midrst_strobe_cnt_hit", cnt_hit, 32'd0);

    // Saturation of the hit counter
    force dut.r_cnt_hit = 32'hFFFF_FFFF;
    tick();
    release dut.r_cnt_hit;
    check("sat_preload", cnt_hit, 32'hFFFF_FFFF);
    accept(K_AAPL, M1);
    respond(1, 1'b1, 10'd37);
    check("sat_out_hit", out_hit, 1'b1);
    check("sat_cnt_hit", cnt_hit, 32'hFFFF_FFFF);
    check("sat_cnt_miss", cnt_miss, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/symtab_lookup_stage.md
# symtab_lookup_stage

Sequencer between the ITCH message parser and `symtab_cam`. Accepts one parsed message (8-byte stock symbol plus metadata) at a time and issues a single lookup to the CAM. Waits for the CAM's variable-latency result, which takes 1–8 probes, and emits the message tagged with the symbol index and hit flag to the book-update stage. Guards against a stalled CAM with a timeout and keeps saturating hit/miss/timeout counters for CSR readback.

## Interface
Parameters:
- KEY_WIDTH, 64, symbol key width (space-padded ASCII)
- IDX_WIDTH, 10, symbol index width; matches CAM
- META_WIDTH, 128, opaque message payload carried alongside the key
- TIMEOUT_CYCLES, 16, maximum cycles in S_WAIT before forced miss; legal range 2–255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  parser message valid
- in_ready  out  1  stage can accept a message
- in_key  in  KEY_WIDTH  symbol key
- in_meta  in  META_WIDTH  message payload
- cam_lookup_key  out  KEY_WIDTH  key presented to CAM
- cam_lookup_valid  out  1  one-cycle lookup request pulse
- cam_lookup_idx  in  IDX_WIDTH  CAM result index
- cam_lookup_hit  in  1  CAM hit flag
- cam_lookup_ready  in  1  one-cycle CAM result strobe
- out_valid  out  1  tagged message valid
- out_ready  in  1  downstream accept
- out_idx  out  IDX_WIDTH  symbol index; 0 on miss
- out_hit  out  1  symbol found
- out_meta  out  META_WIDTH  payload copy
- cnt_hit, cnt_miss, cnt_timeout  out  32 each  saturating event counters

## Operation
- FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT.
- S_IDLE: in_ready=1. On in_valid, register in_key→key_q and in_meta→meta_q, then go to S_REQ.
- S_REQ: cam_lookup_valid=1 for exactly this cycle; cam_lookup_key=key_q (held stable in all non-idle states). Clear the timeout counter, go to S_WAIT.
- S_WAIT: timeout counter increments each cycle.
  - cam_lookup_ready=1: capture idx/hit. If hit, increment cnt_hit; if miss, increment cnt_miss and force out_idx=0. Go to S_OUT.
  - Counter reaches TIMEOUT_CYCLES with no strobe: out_hit=0, out_idx=0, increment cnt_timeout (not cnt_miss), go to S_OUT.
  - A strobe arriving in the same cycle as the timeout is treated as the strobe.
- S_OUT: out_valid=1 with registered out_idx/out_hit/out_meta held stable. On out_ready go to S_IDLE. No new input accepted until then (in_ready=0).
- cam_lookup_ready outside S_WAIT (late strobe after timeout or reset) is ignored.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- One message in flight; no reordering possible.

## Timing
- Reset: state=S_IDLE. in_ready=1; out_valid=0; cam_lookup_valid=0; cam_lookup_key=0; out_idx=0; out_hit=0; out_meta=0; all counters 0.
- Reset mid-operation discards the in-flight message and produces no output for it.
- Acceptance at edge N. The lookup pulse is asserted in cycle N+1. The CAM registers it at edge N+1, probes from N+2, and strobes ready at N+2+p, where p = probes (1–8).
- out_valid first asserts at cycle N+3+p. A first-probe hit has out_valid at N+4.
- Throughput: one message per (4+p) cycles with out_ready=1.
- Downstream stall: out_valid stays high and the payload does not change until out_ready is seen.

## Configuration
- SYMTAB_MISS_DROP_EN:
  - Defined: misses and timeouts skip S_OUT and return directly to S_IDLE. No out_valid is produced; counters still update.
  - Undefined: every accepted message is emitted, with out_hit=0 on miss or timeout.

## Test plan
- Hit: CAM model returns hit, idx=10'd37, p=1 for key "AAPL    ". Required: out_valid at accept+4, out_idx=37, out_hit=1, out_meta echoed, cnt_hit=1.
- Miss, macro undefined: CAM strobes hit=0, idx=5. Required: out_hit=0, out_idx=0, cnt_miss=1. With SYMTAB_MISS_DROP_EN defined: no out_valid, in_ready returns at strobe+1.
- Timeout: CAM never strobes, TIMEOUT_CYCLES=16. Required: out_valid with out_hit=0 and cnt_timeout=1. A strobe injected 3 cycles later is ignored and produces no second output.
- Backpressure: out_ready held low 10 cycles after out_valid. Required: outputs stable and in_ready=0 throughout; the next message is accepted only after the out_ready handshake.
- Reset mid-flight: rst asserted during S_WAIT. Required: next cycle in_ready=1, out_valid=0, counters 0; a CAM strobe arriving afterwards produces no output.
- Saturation: preload cnt_hit to 32'hFFFF_FFFF (force), then issue a hit. Required: cnt_hit stays at 32'hFFFF_FFFF.
